// File: rtl/adder_result_checker.sv
// Response checker for adder DUTs: recomputes a+b+cin, aligns it with the DUT result
// LATENCY cycles later, and keeps pass/fail counts plus the first mismatching vector.
module adder_result_checker #(
    parameter int WIDTH       = 32,
    parameter int LATENCY     = 0,
    parameter int NUM_VECTORS = 40,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic [WIDTH-1:0] i_dut_sum,
    input  logic             i_dut_cout,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic             o_mismatch,
    output logic [CNT_W-1:0] o_first_fail_idx,
    output logic [WIDTH:0]   o_first_exp,
    output logic [WIDTH:0]   o_first_got,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_issue_cnt;
    logic [CNT_W-1:0]   r_cmp_idx;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic [CNT_W-1:0]   r_first_idx;
    logic [WIDTH:0]     r_first_exp;
    logic [WIDTH:0]     r_first_got;
    logic               r_mismatch;
    logic               r_have_fail;

    logic               w_accept;
    logic [WIDTH:0]     w_exp;
    logic [WIDTH:0]     w_got;
    logic               w_cmp_vld;
    logic [WIDTH:0]     w_cmp_exp;
    logic               w_pipe_busy;
    logic               w_match;

    // start wins over everything, so a vector offered with it is dropped
    assign w_accept = i_in_valid && !i_start && (r_state == S_RUN);
    assign w_exp    = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    assign w_got    = {i_dut_cout, i_dut_sum};
    assign w_match  = (w_got == w_cmp_exp);

    // ---- stage boundary: golden result delay line (absent when LATENCY=0) ----
    if (LATENCY == 0) begin : g_nolat
        assign w_cmp_vld   = w_accept;
        assign w_cmp_exp   = w_exp;
        assign w_pipe_busy = 1'b0;
    end else begin : g_lat
        logic [LATENCY-1:0] r_vld_pipe;
        logic [WIDTH:0]     r_exp_pipe [LATENCY];

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_vld_pipe <= '0;
            end else if (i_start) begin
                r_vld_pipe <= '0;
            end else begin
                r_vld_pipe <= (r_vld_pipe << 1) | LATENCY'(w_accept);
            end
        end

        always_ff @(posedge i_clk) begin
            r_exp_pipe[0] <= w_exp;
            for (int i = 1; i < LATENCY; i++) begin
                r_exp_pipe[i] <= r_exp_pipe[i-1];
            end
        end

        assign w_cmp_vld   = r_vld_pipe[LATENCY-1];
        assign w_cmp_exp   = r_exp_pipe[LATENCY-1];
        assign w_pipe_busy = |r_vld_pipe;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_IDLE;
            S_RUN:   if (w_accept && (r_issue_cnt == LAST_IDX)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!w_pipe_busy) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_start) w_state_nxt = S_RUN;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- stage boundary: compare results registered into counters ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_issue_cnt <= '0;
            r_cmp_idx   <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_first_idx <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
            r_mismatch  <= 1'b0;
            r_have_fail <= 1'b0;
        end else if (i_start) begin
            r_issue_cnt <= '0;
            r_cmp_idx   <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_first_idx <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
            r_mismatch  <= 1'b0;
            r_have_fail <= 1'b0;
        end else begin
            r_mismatch <= 1'b0;
            if (w_accept) begin
                r_issue_cnt <= sat_inc(r_issue_cnt);
            end
            if (w_cmp_vld) begin
                r_cmp_idx <= sat_inc(r_cmp_idx);
                if (w_match) begin
                    r_pass_cnt <= sat_inc(r_pass_cnt);
                end else begin
                    r_fail_cnt <= sat_inc(r_fail_cnt);
                    r_mismatch <= 1'b1;
                    if (!r_have_fail) begin
                        r_have_fail <= 1'b1;
                        r_first_idx <= r_cmp_idx;
                        r_first_exp <= w_cmp_exp;
                        r_first_got <= w_got;
                    end
                end
            end
        end
    end

    assign o_pass_cnt       = r_pass_cnt;
    assign o_fail_cnt       = r_fail_cnt;
    assign o_mismatch       = r_mismatch;
    assign o_first_fail_idx = r_first_idx;
    assign o_first_exp      = r_first_exp;
    assign o_first_got      = r_first_got;
    assign o_busy           = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done           = (r_state == S_DONE);

endmodule
